// File: rtl/spi_sched_pkg.sv
// Shared constants for the SPI command scheduler: FSM encodings, command
// layout and stream framing.
package spi_sched_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CMD    = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STREAM = 3'd3;
    localparam logic [2:0] DRAIN  = 3'd4;

    localparam int         CMD_RD_BIT          = 7;
    localparam logic [6:0] STREAM_ADDR_DEFAULT = 7'h7F;
    localparam int         BYTES_PER_SAMPLE    = 2;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizers for the SPI pins plus edge detection on the synced
// sck and ssn. Pin-to-action latency is three clk.
module spi_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic ssn,
    input  logic mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic ssn_rise,
    output logic ssn_fall,
    output logic ssn_s,
    output logic mosi_s
);

    logic sck_m, sck_s, sck_d;
    logic ssn_m, ssn_d;
    logic mosi_m;

    // ssn resets to "selected" so a frame already in flight at reset release
    // is not joined; a real ssn rise then fall is needed to start a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_m  <= 1'b0;
            sck_s  <= 1'b0;
            sck_d  <= 1'b0;
            ssn_m  <= 1'b0;
            ssn_s  <= 1'b0;
            ssn_d  <= 1'b0;
            mosi_m <= 1'b0;
            mosi_s <= 1'b0;
        end else begin
            sck_m  <= sck;
            sck_s  <= sck_m;
            sck_d  <= sck_s;
            ssn_m  <= ssn;
            ssn_s  <= ssn_m;
            ssn_d  <= ssn_s;
            mosi_m <= mosi;
            mosi_s <= mosi_m;
        end
    end

    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign ssn_rise = ssn_s & ~ssn_d;
    assign ssn_fall = ~ssn_s & ssn_d;

endmodule

// File: rtl/spi_cmd_sched.sv
// SPI command scheduler: frames a command byte, then serves a config register
// read/write or a streaming readout of 16-bit samples from the upstream FIFO.
module spi_cmd_sched
    import spi_sched_pkg::*;
#(
    parameter int               SAMPLE_W    = 16,
    parameter int               ADDR_W      = 7,
    parameter logic [ADDR_W-1:0] STREAM_ADDR = STREAM_ADDR_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                spi_sck,
    input  logic                spi_ssn,
    input  logic                spi_mosi,
    output logic                spi_miso,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_ready,
    output logic [ADDR_W-1:0]   cfg_addr,
    input  logic [7:0]          cfg_rdata,
    output logic                cfg_wr_en,
    output logic [7:0]          cfg_wdata,
    output logic                frame_err,
    output logic [7:0]          underrun_cnt,
    output logic [2:0]          state_dbg
);

    localparam int TX_W = 8 * BYTES_PER_SAMPLE;

    logic            sck_rise, sck_fall, ssn_rise, ssn_fall, ssn_s, mosi_s;
    logic [2:0]      state;
    logic [2:0]      bit_cnt;
    logic [6:0]      rx_sr;
    logic [TX_W-1:0] tx_sr;
    logic            is_rd, ld_pend, sample_byte;
    logic [7:0]      rx_byte;
    logic [3:0]      tx_idx;
    logic            active, shifting, byte_done, do_load;

    spi_pin_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .sck      (spi_sck),
        .ssn      (spi_ssn),
        .mosi     (spi_mosi),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .ssn_rise (ssn_rise),
        .ssn_fall (ssn_fall),
        .ssn_s    (ssn_s),
        .mosi_s   (mosi_s)
    );

    assign state_dbg = state;
    assign rx_byte   = {rx_sr, mosi_s};
    assign tx_idx    = {sample_byte, bit_cnt};
    assign active    = (state == CMD) || (state == DATA) || (state == STREAM);
    assign shifting  = (state == STREAM) || ((state == DATA) && is_rd);
    assign byte_done = active && sck_rise && !ssn_s && (bit_cnt == 3'd7);

    // Sample handshake: a sample transfers on the clk where sample_valid and
    // sample_ready are both high; ready is only raised when valid is seen.
    assign do_load = byte_done &&
        (((state == CMD) && rx_byte[CMD_RD_BIT] && (rx_byte[ADDR_W-1:0] == STREAM_ADDR)) ||
         ((state == STREAM) && sample_byte));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= 3'd0;
            rx_sr        <= '0;
            tx_sr        <= '0;
            is_rd        <= 1'b0;
            ld_pend      <= 1'b0;
            sample_byte  <= 1'b0;
            spi_miso     <= 1'b0;
            sample_ready <= 1'b0;
            cfg_addr     <= '0;
            cfg_wr_en    <= 1'b0;
            cfg_wdata    <= 8'h00;
            frame_err    <= 1'b0;
            underrun_cnt <= 8'h00;
        end else begin
            sample_ready <= 1'b0;
            cfg_wr_en    <= 1'b0;
            frame_err    <= 1'b0;
            if (ssn_rise) begin
                // Deselect beats a byte completing in the same clk.
                state    <= IDLE;
                frame_err <= (bit_cnt != 3'd0);
                bit_cnt  <= 3'd0;
                spi_miso <= 1'b0;
                ld_pend  <= 1'b0;
            end else begin
                if (active && sck_rise && !ssn_s) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    rx_sr   <= rx_byte[6:0];
                end
                if (shifting && sck_fall && !ssn_s)
                    spi_miso <= tx_sr[~tx_idx];

                case (state)
                    IDLE: begin
                        if (ssn_fall) begin
                            state       <= CMD;
                            bit_cnt     <= 3'd0;
                            spi_miso    <= 1'b0;
                            sample_byte <= 1'b0;
                        end
                    end
                    CMD: begin
                        if (byte_done) begin
                            is_rd    <= rx_byte[CMD_RD_BIT];
                            cfg_addr <= rx_byte[ADDR_W-1:0];
                            if (do_load)
                                state <= STREAM;
                            else begin
                                state   <= DATA;
                                ld_pend <= rx_byte[CMD_RD_BIT];
                            end
                        end
                    end
                    DATA: begin
                        // cfg_rdata follows cfg_addr, so it is captured one clk after decode.
                        if (ld_pend) begin
                            tx_sr[TX_W-1 -: 8] <= cfg_rdata;
                            spi_miso           <= cfg_rdata[7];
                            ld_pend            <= 1'b0;
                        end
                        if (byte_done) begin
                            if (!is_rd) begin
                                cfg_wdata <= rx_byte;
                                cfg_wr_en <= 1'b1;
                            end
                            state    <= DRAIN;
                            spi_miso <= 1'b0;
                        end
                    end
                    STREAM: begin
                        if (byte_done)
                            sample_byte <= ~sample_byte;
                    end
                    DRAIN: spi_miso <= 1'b0;
                    default: state <= IDLE;
                endcase

                if (do_load) begin
                    if (sample_valid) begin
                        sample_ready <= 1'b1;
                        tx_sr        <= sample_data;
                        spi_miso     <= sample_data[SAMPLE_W-1];
                    end else begin
                        tx_sr    <= '0;
                        spi_miso <= 1'b0;
                        if (underrun_cnt != 8'hFF)
                            underrun_cnt <= underrun_cnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_sched.sv
// Bench for spi_cmd_sched: table of register frames plus hand sequences for
// streaming, underrun, abort, deselect/byte collision and reset mid-frame.
module tb_spi_cmd_sched;
    import spi_sched_pkg::*;

    logic        clk, rst;
    logic        spi_sck, spi_ssn, spi_mosi, spi_miso;
    logic        sample_valid, sample_ready;
    logic [15:0] sample_data;
    logic [6:0]  cfg_addr;
    logic [7:0]  cfg_rdata, cfg_wdata, underrun_cnt;
    logic        cfg_wr_en, frame_err;
    logic [2:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    int ferr_cnt = 0;
    int pop_cnt = 0;

    logic [7:0]  exp_q[$];
    logic [14:0] exp_wr_q[$];
    logic [15:0] fifo_q[$];

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] dat;
        logic       is_wr;
        logic [7:0] exp_rd;
    } vec_t;
    vec_t vecs[7];

    spi_cmd_sched dut (
        .clk          (clk),
        .rst          (rst),
        .spi_sck      (spi_sck),
        .spi_ssn      (spi_ssn),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .cfg_addr     (cfg_addr),
        .cfg_rdata    (cfg_rdata),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_wdata    (cfg_wdata),
        .frame_err    (frame_err),
        .underrun_cnt (underrun_cnt),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- register file / FIFO models ----------------
    function automatic logic [7:0] rd_model(input logic [6:0] a);
        return (a == 7'h12) ? 8'h3C : ({1'b0, a} ^ 8'hA5);
    endfunction

    always_comb cfg_rdata = rd_model(cfg_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fifo_update();
        sample_valid = (fifo_q.size() != 0);
        sample_data  = sample_valid ? fifo_q[0] : 16'h0000;
    endtask

    task automatic fifo_push(input logic [15:0] d);
        fifo_q.push_back(d);
        fifo_update();
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (cfg_wr_en) begin
            if (exp_wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h, required no write", cfg_addr, cfg_wdata);
            end else begin
                check("cfg_write", {cfg_addr, cfg_wdata}, exp_wr_q.pop_front());
            end
        end
        if (frame_err) ferr_cnt++;
        if (sample_ready) begin
            check("ready_needs_valid", sample_valid, 1);
            if (sample_valid) begin
                void'(fifo_q.pop_front());
                pop_cnt++;
            end
        end
        fifo_update();
    end

    // ---------------- SPI driver tasks ----------------
    task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_mosi = b[7-i];
            #40;
            mi = {mi[6:0], spi_miso};
            spi_sck = 1'b1;
            #40;
            spi_sck = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] b);
        logic [7:0] mi;
        send_bits(b, 8, mi);
        if (exp_q.size() != 0) check("miso_byte", mi, exp_q.pop_front());
    endtask

    task automatic ssn_low();
        spi_ssn = 1'b0;
        #80;
    endtask

    task automatic ssn_high();
        #40;
        spi_ssn = 1'b1;
        #160;
    endtask

    task automatic check_reset_vals();
        check("rst_miso", spi_miso, 0);
        check("rst_ready", sample_ready, 0);
        check("rst_wr_en", cfg_wr_en, 0);
        check("rst_wdata", cfg_wdata, 0);
        check("rst_addr", cfg_addr, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_underrun", underrun_cnt, 0);
        check("rst_state", state_dbg, IDLE);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int ferr0, pop0;
        logic [7:0] mi;

        rst = 1'b1;
        spi_sck = 1'b0;
        spi_ssn = 1'b1;
        spi_mosi = 1'b0;
        fifo_update();
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // Register frames: write, read, write to the stream address (plain
        // write), trailing byte in DRAIN must neither write nor drive miso.
        vecs[0] = '{8'h05, 8'hA7, 1'b1, 8'h00};
        vecs[1] = '{8'h92, 8'h00, 1'b0, rd_model(7'h12)};
        vecs[2] = '{8'h8A, 8'hFF, 1'b0, rd_model(7'h0A)};
        vecs[3] = '{8'h7F, 8'h11, 1'b1, 8'h00};
        vecs[4] = '{8'hFE, 8'h00, 1'b0, rd_model(7'h7E)};
        vecs[5] = '{8'h00, 8'h5A, 1'b1, 8'h00};
        vecs[6] = '{8'hA0, 8'h81, 1'b0, rd_model(7'h20)};
        ferr0 = ferr_cnt;
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].is_wr) exp_wr_q.push_back({vecs[v].cmd[6:0], vecs[v].dat});
            exp_q.push_back(8'h00);
            exp_q.push_back(vecs[v].exp_rd);
            exp_q.push_back(8'h00);
            ssn_low();
            xfer(vecs[v].cmd);
            xfer(vecs[v].dat);
            xfer(8'hFF);
            ssn_high();
            check("table_write_drained", exp_wr_q.size(), 0);
        end
        check("table_no_frame_err", ferr_cnt - ferr0, 0);

        // Stream two samples; the third load finds the FIFO empty.
        pop0 = pop_cnt;
        fifo_push(16'h1234);
        fifo_push(16'hBEEF);
        @(negedge clk);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'hBE);
        exp_q.push_back(8'hEF);
        ssn_low();
        xfer(8'hFF);
        for (int b = 0; b < 4; b++) xfer(8'h00);
        ssn_high();
        check("stream_pops", pop_cnt - pop0, 2);
        check("stream_underrun", underrun_cnt, 1);
        check("stream_no_frame_err", ferr_cnt - ferr0, 0);

        // Reset mid-stream with ssn held low.
        pop0 = pop_cnt;
        fifo_push(16'hCAFE);
        @(negedge clk);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hCA);
        ssn_low();
        xfer(8'hFF);
        xfer(8'h00);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        xfer(8'h05);
        xfer(8'h99);
        repeat (4) @(negedge clk);
        check("rst_ignore_state", state_dbg, IDLE);
        check("rst_sample_lost", pop_cnt - pop0, 1);
        ssn_high();
        ferr0 = ferr_cnt;
        exp_wr_q.push_back({7'h09, 8'hC3});
        ssn_low();
        xfer(8'h09);
        xfer(8'hC3);
        ssn_high();
        check("post_rst_write", exp_wr_q.size(), 0);

        // Abort a write frame after 12 sck cycles, then a normal frame.
        ssn_low();
        xfer(8'h33);
        send_bits(8'hC0, 4, mi);
        ssn_high();
        check("abort_frame_err", ferr_cnt - ferr0, 1);
        exp_wr_q.push_back({7'h06, 8'h5A});
        ssn_low();
        xfer(8'h06);
        xfer(8'h5A);
        ssn_high();
        check("abort_next_write", exp_wr_q.size(), 0);
        check("abort_err_once", ferr_cnt - ferr0, 1);

        // ssn rise coincident with the last sck rise of the data byte.
        ferr0 = ferr_cnt;
        ssn_low();
        xfer(8'h44);
        send_bits(8'hAB, 7, mi);
        spi_mosi = 1'b1;
        #40;
        spi_sck = 1'b1;
        spi_ssn = 1'b1;
        #40;
        spi_sck = 1'b0;
        #160;
        check("collide_frame_err", ferr_cnt - ferr0, 1);

        // Underrun: empty FIFO, five data bytes -> three loads, all zero.
        for (int b = 0; b < 6; b++) exp_q.push_back(8'h00);
        ssn_low();
        xfer(8'hFF);
        for (int b = 0; b < 5; b++) xfer(8'h5A);
        ssn_high();
        check("underrun_cnt3", underrun_cnt, 3);

        // 297 more underruns (300 total) saturate the counter.
        for (int f = 0; f < 9; f++) begin
            ssn_low();
            xfer(8'hFF);
            for (int b = 0; b < 64; b++) xfer(8'h00);
            ssn_high();
        end
        check("underrun_sat", underrun_cnt, 255);

        check("miso_queue_empty", exp_q.size(), 0);
        check("write_queue_empty", exp_wr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
